// File: rtl/shift_reg_pkg.sv
// Shared types for the shift_reg_n universal shift register.
// Contents:
//   shift_mode_t : shift operation selected by the Mode input
//   state_t      : sequencer states (IDLE, SHIFT, DONE)
package shift_reg_pkg;

    // Operation encodings; the values match the Mode input bit patterns.
    typedef enum logic [1:0] {
        SH_LSR = 2'b00,   // logical right, Shift_In fills the MSB
        SH_ASR = 2'b01,   // arithmetic right, MSB replicated
        SH_LSL = 2'b10,   // logical left, Shift_In fills the LSB
        SH_ROR = 2'b11    // rotate right (only with SHIFT_REG_ROTATE_EN)
    } shift_mode_t;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_reg_n_shift_step.sv
// shift_step: combinational single-position shifter.
// Ports:
//   data      in  WIDTH  current register contents
//   mode      in  2      operation (shift_mode_t)
//   fill      in  1      fill bit for logical shifts
//   next_data out WIDTH  contents after one step
//   out_bit   out 1      bit shifted or rotated out
// Configuration: SHIFT_REG_ROTATE_EN builds the rotate-right path; without
// it, SH_ROR is treated as a logical right shift.
module shift_step
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] data,
    input  shift_mode_t      mode,
    input  logic             fill,
    output logic [WIDTH-1:0] next_data,
    output logic             out_bit
);

    // One-position shift selected by mode.
    always_comb begin
        next_data = data;
        out_bit   = 1'b0;
        case (mode)
            SH_LSR: begin
                next_data = {fill, data[WIDTH-1:1]};
                out_bit   = data[0];
            end
            SH_ASR: begin
                next_data = {data[WIDTH-1], data[WIDTH-1:1]};
                out_bit   = data[0];
            end
            SH_LSL: begin
                next_data = {data[WIDTH-2:0], fill};
                out_bit   = data[WIDTH-1];
            end
            SH_ROR: begin
`ifdef SHIFT_REG_ROTATE_EN
                next_data = {data[0], data[WIDTH-1:1]};
                out_bit   = data[0];
`else
                // Rotate not built: identical to logical right.
                next_data = {fill, data[WIDTH-1:1]};
                out_bit   = data[0];
`endif
            end
            default: begin
                next_data = data;
                out_bit   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_reg_n.sv
// shift_reg_n: parametrised universal shift register with a multi-step
// shift sequencer and Start/Busy/Done handshake.
// Ports:
//   Clk       in  1      clock, rising edge
//   Reset     in  1      synchronous active-high reset
//   Load      in  1      parallel load of D (idle only, beats Start)
//   D         in  WIDTH  parallel load data
//   Start     in  1      begin a multi-step shift (idle only)
//   Mode      in  2      00 LSR, 01 ASR, 10 LSL, 11 ROR
//   Amount    in  AW     shift amount, saturates to WIDTH
//   Shift_In  in  1      fill bit, resampled every step
//   Data_Out  out WIDTH  register contents
//   Shift_Out out 1      last bit shifted out
//   Busy      out 1      high whenever not idle
//   Done      out 1      one-cycle completion pulse
// Configuration: SHIFT_REG_ROTATE_EN enables rotate right for Mode 11.
module shift_reg_n
    import shift_reg_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int AW    = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    input  logic             Start,
    input  logic [1:0]       Mode,
    input  logic [AW-1:0]    Amount,
    input  logic             Shift_In,
    output logic [WIDTH-1:0] Data_Out,
    output logic             Shift_Out,
    output logic             Busy,
    output logic             Done
);

    state_t            state_r;
    shift_mode_t       mode_r;
    logic [AW-1:0]     count_r;
    logic [WIDTH-1:0]  data_r;
    logic              sout_r;
    logic              busy_r;
    logic              done_r;

    logic [AW-1:0]     amt_sat_s;
    logic [WIDTH-1:0]  step_data_s;
    logic              step_out_s;

    // Clamp the requested amount to WIDTH.
    always_comb begin
        amt_sat_s = Amount;
        if (Amount > AW'(WIDTH)) begin
            amt_sat_s = AW'(WIDTH);
        end else begin
            amt_sat_s = Amount;
        end
    end

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .data      (data_r),
        .mode      (mode_r),
        .fill      (Shift_In),
        .next_data (step_data_s),
        .out_bit   (step_out_s)
    );

    // Sequencer FSM with registered data and handshake outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= IDLE;
            mode_r  <= SH_LSR;
            count_r <= '0;
            data_r  <= '0;
            sout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (Load) begin
                        // Load wins; a coincident Start is dropped.
                        data_r <= D;
                        sout_r <= 1'b0;
                        busy_r <= 1'b0;
                    end else if (Start) begin
                        mode_r  <= shift_mode_t'(Mode);
                        count_r <= amt_sat_s;
                        busy_r  <= 1'b1;
                        if (amt_sat_s == AW'(0)) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= SHIFT;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                SHIFT: begin
                    data_r  <= step_data_s;
                    sout_r  <= step_out_s;
                    count_r <= count_r - AW'(1);
                    // The step that empties the count finishes the operation.
                    if (count_r == AW'(1)) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= SHIFT;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    count_r <= '0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    count_r <= '0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign Data_Out  = data_r;
    assign Shift_Out = sout_r;
    assign Busy      = busy_r;
    assign Done      = done_r;

endmodule

// File: tb/tb_shift_reg_n.sv
// Directed self-checking bench for shift_reg_n (WIDTH=16).
module tb_shift_reg_n;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Load;
    logic [15:0] D;
    logic        Start;
    logic [1:0]  Mode;
    logic [4:0]  Amount;
    logic        Shift_In;
    logic [15:0] Data_Out;
    logic        Shift_Out;
    logic        Busy;
    logic        Done;

    int n_total = 0;
    int n_bad   = 0;

    int busy_cnt;
    int done_cnt;
    int done_at;

    shift_reg_n #(.WIDTH(16)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Load      (Load),
        .D         (D),
        .Start     (Start),
        .Mode      (Mode),
        .Amount    (Amount),
        .Shift_In  (Shift_In),
        .Data_Out  (Data_Out),
        .Shift_Out (Shift_Out),
        .Busy      (Busy),
        .Done      (Done)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and move 1 time unit past it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Sample Busy/Done for a fixed number of cycles starting now.
    task automatic observe(input int cycles, output int b_cnt, output int d_cnt, output int d_at);
        b_cnt = 0;
        d_cnt = 0;
        d_at  = -1;
        for (int k = 0; k < cycles; k++) begin
            if (Busy === 1'b1) b_cnt++;
            if (Done === 1'b1) begin
                d_cnt++;
                d_at = k;
            end
            tick();
        end
    endtask

    task automatic do_load(input logic [15:0] val);
        Load = 1'b1;
        D    = val;
        tick();
        Load = 1'b0;
    endtask

    // Issue Start; returns just after the sampling edge t0.
    task automatic do_start(input logic [1:0] m, input logic [4:0] amt, input logic fill);
        Start    = 1'b1;
        Mode     = m;
        Amount   = amt;
        Shift_In = fill;
        tick();
        Start = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; Load = 1'b0; D = 16'h0000; Start = 1'b0;
        Mode = 2'b00; Amount = 5'd0; Shift_In = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        check_eq("rst_data", 32'(Data_Out), 32'h0);
        check_eq("rst_sout", 32'(Shift_Out), 32'h0);
        check_eq("rst_busy", 32'(Busy), 32'h0);
        check_eq("rst_done", 32'(Done), 32'h0);

        // Parallel load
        do_load(16'hA5F0);
        check_eq("load_data", 32'(Data_Out), 32'hA5F0);
        check_eq("load_busy", 32'(Busy), 32'h0);
        check_eq("load_done", 32'(Done), 32'h0);

        // Arithmetic right by 4
        do_load(16'h8001);
        do_start(2'b01, 5'd4, 1'b0);
        observe(8, busy_cnt, done_cnt, done_at);
        check_eq("asr_busy_cycles", 32'(busy_cnt), 32'd5);
        check_eq("asr_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("asr_done_at", 32'(done_at), 32'd4);
        check_eq("asr_data", 32'(Data_Out), 32'hF800);
        check_eq("asr_sout", 32'(Shift_Out), 32'h0);

        // Logical left with saturating amount
        do_load(16'hFFFF);
        do_start(2'b10, 5'd20, 1'b0);
        observe(20, busy_cnt, done_cnt, done_at);
        check_eq("lsl_busy_cycles", 32'(busy_cnt), 32'd17);
        check_eq("lsl_done_at", 32'(done_at), 32'd16);
        check_eq("lsl_done_cnt", 32'(done_cnt), 32'd1);
        check_eq("lsl_data", 32'(Data_Out), 32'h0000);
        check_eq("lsl_sout", 32'(Shift_Out), 32'h1);

        // Logical right by WIDTH with fill 1
        do_load(16'h0000);
        do_start(2'b00, 5'd16, 1'b1);
        observe(19, busy_cnt, done_cnt, done_at);
        check_eq("lsr16_data", 32'(Data_Out), 32'hFFFF);
        check_eq("lsr16_sout", 32'(Shift_Out), 32'h0);
        check_eq("lsr16_done_at", 32'(done_at), 32'd16);

        // Amount zero
        do_load(16'h1234);
        do_start(2'b00, 5'd0, 1'b1);
        observe(3, busy_cnt, done_cnt, done_at);
        check_eq("amt0_busy_cycles", 32'(busy_cnt), 32'd1);
        check_eq("amt0_done_at", 32'(done_at), 32'd0);
        check_eq("amt0_data", 32'(Data_Out), 32'h1234);
        check_eq("amt0_sout", 32'(Shift_Out), 32'h0);

        // Load and Start together: load only
        Load = 1'b1; D = 16'h5A5A; Start = 1'b1; Mode = 2'b00; Amount = 5'd3; Shift_In = 1'b0;
        tick();
        Load = 1'b0; Start = 1'b0;
        observe(5, busy_cnt, done_cnt, done_at);
        check_eq("ldst_busy", 32'(busy_cnt), 32'd0);
        check_eq("ldst_done", 32'(done_cnt), 32'd0);
        check_eq("ldst_data", 32'(Data_Out), 32'h5A5A);

        // Start and Load while busy are ignored
        do_start(2'b00, 5'd2, 1'b0);
        Start = 1'b1; Load = 1'b1; D = 16'hFFFF; Mode = 2'b10; Amount = 5'd5;
        tick();
        Start = 1'b0; Load = 1'b0;
        observe(5, busy_cnt, done_cnt, done_at);
        check_eq("busy_ign_busy", 32'(busy_cnt), 32'd2);
        check_eq("busy_ign_done", 32'(done_cnt), 32'd1);
        check_eq("busy_ign_data", 32'(Data_Out), 32'h1696);
        check_eq("busy_ign_sout", 32'(Shift_Out), 32'h1);

        // Reset mid-shift
        do_load(16'hFF00);
        do_start(2'b00, 5'd8, 1'b0);
        tick();
        tick();
        check_eq("mid_data", 32'(Data_Out), 32'h3FC0);
        check_eq("mid_busy", 32'(Busy), 32'h1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check_eq("abort_data", 32'(Data_Out), 32'h0);
        check_eq("abort_busy", 32'(Busy), 32'h0);
        check_eq("abort_sout", 32'(Shift_Out), 32'h0);
        check_eq("abort_done_now", 32'(Done), 32'h0);
        observe(12, busy_cnt, done_cnt, done_at);
        check_eq("abort_done_later", 32'(done_cnt), 32'd0);
        check_eq("abort_busy_later", 32'(busy_cnt), 32'd0);

        // Mode 11
        do_load(16'h0001);
        do_start(2'b11, 5'd1, 1'b0);
        observe(4, busy_cnt, done_cnt, done_at);
`ifdef SHIFT_REG_ROTATE_EN
        check_eq("ror_data", 32'(Data_Out), 32'h8000);
`else
        check_eq("ror_data", 32'(Data_Out), 32'h0000);
`endif
        check_eq("ror_sout", 32'(Shift_Out), 32'h1);
        check_eq("ror_done_at", 32'(done_at), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
